// File: rtl/mdu_seq_pkg.sv
// Shared MDU definitions: op codes, FSM state type and op-class helpers for hazard logic.
// Latency: n/a (declarations only).
// Backpressure: n/a; the controller stalls on start|busy using these helpers.
package mdu_seq_pkg;

    localparam logic [3:0] MDU_MULT  = 4'd0;
    localparam logic [3:0] MDU_MULTU = 4'd1;
    localparam logic [3:0] MDU_DIV   = 4'd2;
    localparam logic [3:0] MDU_DIVU  = 4'd3;
    localparam logic [3:0] MDU_MADD  = 4'd4;
    localparam logic [3:0] MDU_MADDU = 4'd5;
    localparam logic [3:0] MDU_MSUB  = 4'd6;
    localparam logic [3:0] MDU_MSUBU = 4'd7;
    localparam logic [3:0] MDU_MTHI  = 4'd8;
    localparam logic [3:0] MDU_MTLO  = 4'd9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_t;

    // Ops that occupy the unit for a multi-cycle busy window.
    function automatic logic is_mdu_busy_op(input logic [3:0] op);
        return (op <= MDU_MSUBU);
    endfunction

    // Ops whose result depends on the current HI/LO contents (accumulate class).
    function automatic logic is_mdu_read(input logic [3:0] op);
        return (op >= MDU_MADD) && (op <= MDU_MSUBU);
    endfunction

endpackage

// File: rtl/mdu_core_comb.sv
// Combinational 2*WIDTH MDU result {hi,lo} for op/A/B and current HI/LO, incl. divide corner cases.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the sequencer decides when the result is captured.
module mdu_core_comb
    import mdu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [WIDTH-1:0]   hi,
    input  logic [WIDTH-1:0]   lo,
    output logic [2*WIDTH-1:0] res
);

    logic                 sg;
    logic [2*WIDTH-1:0]   ax, bx, prod, acc;
    logic                 na, nb;
    logic [WIDTH-1:0]     ma, mb, dvs, uq, ur, q, r;

    // Extend operands to 2*WIDTH by op signedness; the truncated product is then correct mod 2^(2W).
    always_comb begin
        sg   = ~op[0];
        ax   = sg ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
        bx   = sg ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
        prod = ax * bx;
        acc  = {hi, lo};
    end

    // Sign-magnitude truncating divide; most-negative / -1 falls out as q = A, r = 0.
    always_comb begin
        na  = sg & A[WIDTH-1];
        nb  = sg & B[WIDTH-1];
        ma  = na ? -A : A;
        mb  = nb ? -B : B;
        dvs = (mb == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mb;
        uq  = ma / dvs;
        ur  = ma % dvs;
        q   = (na ^ nb) ? -uq : uq;
        r   = na ? -ur : ur;
        if (B == '0) begin
            q = '1;
            r = A;
        end
    end

    // Select the result for the requested op; non-arithmetic codes return HI/LO unchanged.
    always_comb begin
        res = acc;
        case (op)
            MDU_MULT, MDU_MULTU: res = prod;
            MDU_DIV,  MDU_DIVU:  res = {r, q};
            MDU_MADD, MDU_MADDU: res = acc + prod;
            MDU_MSUB, MDU_MSUBU: res = acc - prod;
            default:             res = acc;
        endcase
    end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit with HI/LO; result captured at start, committed after N busy cycles.
// Latency: MUL_CYCLES or DIV_CYCLES busy cycles; MTHI/MTLO visible the cycle after start.
// Backpressure: start is dropped while busy; the pipeline must stall on start|busy.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    mdu_state_t           state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   pend;
    logic [2*WIDTH-1:0]   res;
    logic                 take;
    logic                 last;

    mdu_core_comb #(.WIDTH(WIDTH)) u_core (
        .op  (op),
        .A   (A),
        .B   (B),
        .hi  (hi),
        .lo  (lo),
        .res (res)
    );

    assign take = (state == ST_IDLE) && start && is_mdu_busy_op(op);
    assign last = (state == ST_BUSY) && (cnt == CW'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state: enter BUSY on an accepted arithmetic op, leave on the final count.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (take) state_nxt = ST_BUSY;
            ST_BUSY: if (last) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Busy output decoded from state.
    always_comb begin
        busy = (state == ST_BUSY);
    end

    // Datapath: capture pending result and counter at start, apply MTHI/MTLO, commit on last busy cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            pend <= '0;
            cnt  <= '0;
        end else if (state == ST_IDLE) begin
            if (take) begin
                pend <= res;
                cnt  <= (op == MDU_DIV || op == MDU_DIVU) ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
            end else if (start && op == MDU_MTHI) begin
                hi <= A;
            end else if (start && op == MDU_MTLO) begin
                lo <= A;
            end
        end else begin
            cnt <= cnt - CW'(1);
            if (last) {hi, lo} <= pend;
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed corner cases plus randomized ops against a reference model.
// Latency: checks busy-window length per op class and commit timing.
// Backpressure: checks that start is ignored while busy.
module tb_mdu_seq;
    import mdu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start16;
    logic [3:0]  op, op16;
    logic [31:0] a, b, hi, lo;
    logic [15:0] a16, b16, hi16, lo16;
    logic        busy, busy16;

    int checks = 0;
    int passed = 0;
    longint unsigned m_acc;

    always #5 clk = ~clk;

    mdu_seq #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(a), .B(b),
        .busy(busy), .hi(hi), .lo(lo)
    );

    mdu_seq #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .op(op16), .A(a16), .B(b16),
        .busy(busy16), .hi(hi16), .lo(lo16)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: new {hi,lo} from plain integer arithmetic at width w.
    function automatic longint unsigned mdl(input int w, input logic [3:0] o,
                                            input longint unsigned x, input longint unsigned y,
                                            input longint unsigned h, input longint unsigned l);
        longint unsigned m1, m2, acc, r;
        longint sx, sy, q, rm;
        bit sg;
        m1  = (64'd1 << w) - 1;
        m2  = (w >= 32) ? 64'hFFFF_FFFF_FFFF_FFFF : (64'd1 << (2 * w)) - 1;
        sg  = (o == 4'd0 || o == 4'd2 || o == 4'd4 || o == 4'd6);
        sx  = sg ? ($signed(x << (64 - w)) >>> (64 - w)) : $signed(x);
        sy  = sg ? ($signed(y << (64 - w)) >>> (64 - w)) : $signed(y);
        acc = (h << w) | l;
        case (o)
            4'd0, 4'd1: r = sx * sy;
            4'd2, 4'd3: begin
                if (y == 0) r = (x << w) | m1;
                else begin
                    q  = sx / sy;
                    rm = sx % sy;
                    r  = ((rm & m1) << w) | (q & m1);
                end
            end
            4'd4, 4'd5: r = acc + sx * sy;
            4'd6, 4'd7: r = acc - sx * sy;
            4'd8:       r = (x << w) | l;
            4'd9:       r = (h << w) | x;
            default:    r = acc;
        endcase
        return r & m2;
    endfunction

    // Issue one op on the 32-bit unit, count busy cycles, note whether HI/LO held during busy.
    task automatic run32(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int ncyc, output bit held);
        logic [31:0] h0, l0;
        h0 = hi; l0 = lo; held = 1'b1;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        ncyc = 0;
        while (busy === 1'b1 && ncyc < 200) begin
            ncyc++;
            if (hi !== h0 || lo !== l0) held = 1'b0;
            @(posedge clk); #1;
        end
        m_acc = mdl(32, o, x, y, m_acc >> 32, m_acc & 64'hFFFF_FFFF);
    endtask

    task automatic run16(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                         output int ncyc);
        start16 = 1'b1; op16 = o; a16 = x; b16 = y;
        @(posedge clk); #1;
        start16 = 1'b0;
        ncyc = 0;
        while (busy16 === 1'b1 && ncyc < 200) begin
            ncyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        m_acc = 0;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        checks++; if (hi !== 32'h0) $display("FAIL reset_hi: got %h want 0", hi); else passed++;
        checks++; if (lo !== 32'h0) $display("FAIL reset_lo: got %h want 0", lo); else passed++;
        checks++; if (busy16 !== 1'b0 || hi16 !== 16'h0 || lo16 !== 16'h0)
            $display("FAIL reset_w16: got busy=%b hi=%h lo=%h want 0/0/0", busy16, hi16, lo16); else passed++;
    endtask

    task automatic test_mult();
        int n; bit h;
        run32(MDU_MULT, 32'hFFFF_FFFE, 32'd3, n, h);
        checks++; if (n != 5) $display("FAIL mult_busy: got %0d want 5", n); else passed++;
        checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA)
            $display("FAIL mult_res: got %h_%h want ffffffff_fffffffa", hi, lo); else passed++;
        checks++; if (!h) $display("FAIL mult_held: got changed want held"); else passed++;
        run32(MDU_MULTU, 32'hFFFF_FFFE, 32'd3, n, h);
        checks++; if (n != 5) $display("FAIL multu_busy: got %0d want 5", n); else passed++;
        checks++; if (hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFFA)
            $display("FAIL multu_res: got %h_%h want 00000002_fffffffa", hi, lo); else passed++;
    endtask

    task automatic test_div();
        int n; bit h;
        run32(MDU_DIV, 32'hFFFF_FFF9, 32'd2, n, h);
        checks++; if (n != 10) $display("FAIL div_busy: got %0d want 10", n); else passed++;
        checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF)
            $display("FAIL div_res: got hi=%h lo=%h want ffffffff/fffffffd", hi, lo); else passed++;
        checks++; if (!h) $display("FAIL div_held: got changed want held"); else passed++;
        run32(MDU_DIVU, 32'd7, 32'd0, n, h);
        checks++; if (n != 10) $display("FAIL divu0_busy: got %0d want 10", n); else passed++;
        checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'd7)
            $display("FAIL divu0_res: got hi=%h lo=%h want 00000007/ffffffff", hi, lo); else passed++;
        run32(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n, h);
        checks++; if (lo !== 32'h8000_0000 || hi !== 32'h0)
            $display("FAIL div_ovf: got hi=%h lo=%h want 00000000/80000000", hi, lo); else passed++;
    endtask

    task automatic test_mthi_mtlo_accumulate();
        int n; bit h;
        start = 1'b1; op = MDU_MTHI; a = 32'h1234_5678; b = 32'h0;
        @(posedge clk); #1;
        checks++; if (hi !== 32'h1234_5678 || busy !== 1'b0)
            $display("FAIL mthi: got hi=%h busy=%b want 12345678/0", hi, busy); else passed++;
        op = MDU_MTLO; a = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (lo !== 32'h9ABC_DEF0 || busy !== 1'b0)
            $display("FAIL mtlo: got lo=%h busy=%b want 9abcdef0/0", lo, busy); else passed++;
        m_acc = 64'h1234_5678_9ABC_DEF0;
        run32(MDU_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n, h);
        checks++; if (n != 5) $display("FAIL maddu_busy: got %0d want 5", n); else passed++;
        checks++; if ({hi, lo} !== m_acc)
            $display("FAIL maddu_res: got %h_%h want %h", hi, lo, m_acc); else passed++;
    endtask

    task automatic test_ignore_while_busy();
        int n;
        start = 1'b1; op = MDU_MULT; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        op = MDU_MTLO; a = 32'hDEAD;
        @(posedge clk); #1;
        op = MDU_MULT; a = 32'd5; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        n = 2;
        while (busy === 1'b1 && n < 200) begin n++; @(posedge clk); #1; end
        checks++; if (n != 5) $display("FAIL ignore_busy_len: got %0d want 5", n); else passed++;
        checks++; if (lo !== 32'd12 || hi !== 32'd0)
            $display("FAIL ignore_res: got hi=%h lo=%h want 0/c", hi, lo); else passed++;
        repeat (8) @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || lo !== 32'd12)
            $display("FAIL ignore_no_second: got busy=%b lo=%h want 0/c", busy, lo); else passed++;
        m_acc = 64'd12;
    endtask

    task automatic test_reset_mid_busy();
        start = 1'b1; op = MDU_DIV; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++; if (busy !== 1'b1) $display("FAIL rst_mid_pre: got busy=%b want 1", busy); else passed++;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0)
            $display("FAIL rst_mid: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo); else passed++;
        repeat (12) @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0)
            $display("FAIL rst_no_commit: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo); else passed++;
        m_acc = 0;
    endtask

    task automatic test_reset_and_start();
        reset = 1'b1; start = 1'b1; op = MDU_MTHI; a = 32'hCAFE_F00D;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        checks++; if (hi !== 32'h0 || busy !== 1'b0)
            $display("FAIL rst_wins: got hi=%h busy=%b want 0/0", hi, busy); else passed++;
        m_acc = 0;
    endtask

    task automatic test_random();
        int n, want_n; bit h;
        logic [3:0] o;
        logic [31:0] x, y;
        logic [31:0] corners [5];
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        for (int i = 0; i < 40; i++) begin
            o = 4'($urandom_range(0, 13));
            x = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            case ($urandom_range(0, 5))
                0:       y = 32'h0;
                1:       y = corners[$urandom_range(0, 4)];
                default: y = $urandom;
            endcase
            want_n = (o <= 4'd7) ? ((o == 4'd2 || o == 4'd3) ? 10 : 5) : 0;
            run32(o, x, y, n, h);
            checks++; if (n != want_n)
                $display("FAIL rnd_busy[%0d] op=%0d: got %0d want %0d", i, o, n, want_n); else passed++;
            checks++; if ({hi, lo} !== m_acc)
                $display("FAIL rnd_res[%0d] op=%0d a=%h b=%h: got %h_%h want %h", i, o, x, y, hi, lo, m_acc);
            else passed++;
            if (want_n != 0) begin
                checks++; if (!h) $display("FAIL rnd_held[%0d]: got changed want held", i); else passed++;
            end
        end
    endtask

    task automatic test_param16();
        int n;
        run16(MDU_MSUB, 16'd2, 16'd3, n);
        checks++; if (n != 1) $display("FAIL w16_msub_busy: got %0d want 1", n); else passed++;
        checks++; if ({hi16, lo16} !== 32'hFFFF_FFFA)
            $display("FAIL w16_msub_res: got %h_%h want ffff_fffa", hi16, lo16); else passed++;
        run16(MDU_DIVU, 16'd100, 16'd7, n);
        checks++; if (n != 3) $display("FAIL w16_divu_busy: got %0d want 3", n); else passed++;
        checks++; if (lo16 !== 16'd14 || hi16 !== 16'd2)
            $display("FAIL w16_divu_res: got hi=%0d lo=%0d want 2/14", hi16, lo16); else passed++;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0;
        start16 = 1'b0; op16 = 4'd0; a16 = '0; b16 = '0;
        m_acc = 0;
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo_accumulate();
        test_ignore_while_busy();
        test_reset_mid_busy();
        test_reset_and_start();
        test_random();
        test_param16();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
